// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the CPU-to-Wishbone master bridge.
// State encoding, read-fault pattern and timeout reload are derived from the bridge parameters.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;

    // Value returned to the CPU when a read ends in error or timeout.
    function automatic logic [63:0] read_fault(input int unsigned dw);
        return (dw >= 64) ? '1 : ((64'd1 << dw) - 64'd1);
    endfunction

    // Counter reload so that a strobe lasts at most 2^tow cycles.
    function automatic logic [31:0] timeout_reload(input int unsigned tow);
        return (tow >= 32) ? '1 : ((32'd1 << tow) - 32'd1);
    endfunction

endpackage

// File: rtl/wb_wr_fifo.sv
// Posted-write FIFO: synchronous, first-word-fall-through head, extra pointer bit for full/empty.
module wb_wr_fifo #(
    parameter int W = 16,
    parameter int D = 4,
    localparam int PW = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0] mem_q [D];
    logic [PW:0]  wr_ptr_q;
    logic [PW:0]  rd_ptr_q;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == (PW+1)'(D));
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign dout_o  = mem_q[rd_ptr_q[PW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o)
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop_i && !empty_o)
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i && !full_o)
            mem_q[wr_ptr_q[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/wb_master_bridge.sv
// CPU-to-Wishbone master with posted writes, read stall, error/timeout termination and sticky status.
module wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int TOW = 4,
    parameter int PWD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          rdy,
    input  logic          stat_clr,
    output logic          to_flag,
    output logic          err_flag,
    output logic          wb_stbo,
    output logic          wb_weo,
    output logic [AW-1:0] wb_adro,
    output logic [DW-1:0] wb_dato,
    input  logic          wb_acki,
    input  logic          wb_erri,
    input  logic [DW-1:0] wb_dati
);

    localparam int            CW        = $clog2(PWD) + 1;
    localparam logic [DW-1:0] FAULT     = DW'(read_fault(DW));
    localparam logic [TOW-1:0] TO_RELOAD = TOW'(timeout_reload(TOW));

    state_e         state_q;
    logic [TOW-1:0] tcnt_q;
    logic           wb_stbo_q, wb_weo_q;
    logic [AW-1:0]  wb_adro_q, rd_addr_q;
    logic [DW-1:0]  wb_dato_q, dout_q;
    logic           rdy_q, rdy_d;
    logic           rd_pending_q, rd_pending_d;
    logic           to_flag_q, to_flag_d, err_flag_q, err_flag_d;

    logic              accept, rd_accept, fifo_push, fifo_pop;
    logic [AW+DW-1:0]  fifo_head;
    logic [CW-1:0]     fifo_count, fifo_count_d;
    logic              fifo_full, fifo_empty;
    logic              in_stb, term_ack, term_err, term_to, term;

    wb_wr_fifo #(.W(AW + DW), .D(PWD)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   ({addr, din}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        accept    = cs && rdy_q;
        fifo_push = accept && we && !fifo_full;
        rd_accept = accept && !we;
        fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

        // Termination priority: ack over err over timeout.
        in_stb   = (state_q != ST_IDLE);
        term_ack = in_stb && wb_acki;
        term_err = in_stb && !wb_acki && wb_erri;
        term_to  = in_stb && !wb_acki && !wb_erri && (tcnt_q == '0);
        term     = term_ack || term_err || term_to;

        rd_pending_d = rd_pending_q;
        if (rd_accept)
            rd_pending_d = 1'b1;
        else if ((state_q == ST_RD) && term)
            rd_pending_d = 1'b0;

        fifo_count_d = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
        rdy_d        = (fifo_count_d != CW'(PWD)) && !rd_pending_d;

        // A set event in the same cycle as stat_clr wins.
        to_flag_d  = term_to  ? 1'b1 : (stat_clr ? 1'b0 : to_flag_q);
        err_flag_d = term_err ? 1'b1 : (stat_clr ? 1'b0 : err_flag_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tcnt_q       <= '0;
            wb_stbo_q    <= 1'b0;
            wb_weo_q     <= 1'b0;
            wb_adro_q    <= '0;
            wb_dato_q    <= '0;
            rd_addr_q    <= '0;
            dout_q       <= '0;
            rdy_q        <= 1'b1;
            rd_pending_q <= 1'b0;
            to_flag_q    <= 1'b0;
            err_flag_q   <= 1'b0;
        end else begin
            rdy_q        <= rdy_d;
            rd_pending_q <= rd_pending_d;
            to_flag_q    <= to_flag_d;
            err_flag_q   <= err_flag_d;
            if (rd_accept)
                rd_addr_q <= addr;

            case (state_q)
                ST_IDLE: begin
                    // Queued writes go first so a read observes every earlier write.
                    if (!fifo_empty) begin
                        state_q                <= ST_WR;
                        wb_stbo_q              <= 1'b1;
                        wb_weo_q               <= 1'b1;
                        {wb_adro_q, wb_dato_q} <= fifo_head;
                        tcnt_q                 <= TO_RELOAD;
                    end else if (rd_pending_q) begin
                        state_q   <= ST_RD;
                        wb_stbo_q <= 1'b1;
                        wb_weo_q  <= 1'b0;
                        wb_adro_q <= rd_addr_q;
                        tcnt_q    <= TO_RELOAD;
                    end
                end
                ST_WR, ST_RD: begin
                    if (term) begin
                        state_q   <= ST_IDLE;
                        wb_stbo_q <= 1'b0;
                        if (state_q == ST_RD)
                            dout_q <= term_ack ? wb_dati : FAULT;
                    end else begin
                        tcnt_q <= tcnt_q - TOW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dout     = dout_q;
    assign rdy      = rdy_q;
    assign to_flag  = to_flag_q;
    assign err_flag = err_flag_q;
    assign wb_stbo  = wb_stbo_q;
    assign wb_weo   = wb_weo_q;
    assign wb_adro  = wb_adro_q;
    assign wb_dato  = wb_dato_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: table of single transactions plus multi-cycle sequences.
module tb_wb_master_bridge;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_BOTH = 3;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] din;
        int         mode;
        int         wait_c;
        logic [7:0] dati;
        logic [7:0] exp_dout;
        int         exp_len;
        int         exp_stall;
        logic       exp_to;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] adr;
        logic [7:0] dat;
        logic       we;
    } bus_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0, we = 1'b0, stat_clr = 1'b0;
    logic [7:0] addr = '0, din = '0;
    logic [7:0] dout, wb_adro, wb_dato;
    logic       rdy, to_flag, err_flag, wb_stbo, wb_weo;
    logic       wb_acki = 1'b0, wb_erri = 1'b0;
    logic [7:0] wb_dati = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int         resp_mode = M_NONE;
    int         resp_wait = 0;
    logic [7:0] resp_data = '0;

    int   n_starts = 0, n_done = 0, stb_len = 0, last_len = 0, unstable = 0;
    logic mon_prev = 1'b0;
    bus_t cap;
    bus_t log_q[$];

    always #5 clk = ~clk;

    wb_master_bridge #(.AW(8), .DW(8), .TOW(4), .PWD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .we       (we),
        .addr     (addr),
        .din      (din),
        .dout     (dout),
        .rdy      (rdy),
        .stat_clr (stat_clr),
        .to_flag  (to_flag),
        .err_flag (err_flag),
        .wb_stbo  (wb_stbo),
        .wb_weo   (wb_weo),
        .wb_adro  (wb_adro),
        .wb_dato  (wb_dato),
        .wb_acki  (wb_acki),
        .wb_erri  (wb_erri),
        .wb_dati  (wb_dati)
    );

    // Wishbone slave model and bus monitor; runs 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        wb_acki = 1'b0;
        wb_erri = 1'b0;
        if (wb_stbo) begin
            if (!mon_prev) begin
                cap = '{wb_adro, wb_dato, wb_weo};
                log_q.push_back(cap);
                n_starts++;
                stb_len = 0;
            end else if ({wb_adro, wb_dato, wb_weo} != {cap.adr, cap.dat, cap.we}) begin
                unstable++;
            end
            if (stb_len == resp_wait) begin
                wb_dati = resp_data;
                wb_acki = (resp_mode == M_ACK) || (resp_mode == M_BOTH);
                wb_erri = (resp_mode == M_ERR) || (resp_mode == M_BOTH);
            end
            stb_len++;
        end else if (mon_prev) begin
            last_len = stb_len;
            n_done++;
        end
        mon_prev = wb_stbo;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Present a request and hold it until accepted; leaves us just after the accept edge.
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
        logic acc;
        cs = 1'b1; we = w; addr = a; din = d;
        for (int k = 0; k < 64; k++) begin
            acc = rdy;
            tick();
            if (acc) begin
                cs = 1'b0;
                return;
            end
        end
        cs = 1'b0;
        bound_fail("accept");
    endtask

    // Wait for the given number of terminations with rdy high; counts rdy-low samples.
    task automatic wait_done(input int target, output int stall);
        stall = 0;
        for (int k = 0; k < 200; k++) begin
            if (!rdy) stall++;
            if (n_done >= target && rdy) return;
            tick();
        end
        bound_fail("done");
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base, done0, stall;
        string tag;
        tag = $sformatf("v%0d", idx);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check({tag, "_clr_to"}, int'(to_flag), 0);
        check({tag, "_clr_err"}, int'(err_flag), 0);
        resp_mode = v.mode; resp_wait = v.wait_c; resp_data = v.dati;
        base = n_starts; done0 = n_done;
        issue(v.we, v.addr, v.din);
        wait_done(done0 + 1, stall);
        check({tag, "_nstb"}, n_starts - base, 1);
        if (log_q.size() > base) begin
            check({tag, "_adr"}, int'(log_q[base].adr), int'(v.addr));
            check({tag, "_we"}, int'(log_q[base].we), int'(v.we));
            if (v.we) check({tag, "_dat"}, int'(log_q[base].dat), int'(v.din));
        end
        check({tag, "_len"}, last_len, v.exp_len);
        check({tag, "_stall"}, stall, v.exp_stall);
        if (!v.we) check({tag, "_dout"}, int'(dout), int'(v.exp_dout));
        check({tag, "_to"}, int'(to_flag), int'(v.exp_to));
        check({tag, "_err"}, int'(err_flag), int'(v.exp_err));
    endtask

    initial begin
        vec_t vecs[10];
        int   base, done0, stall, q_cnt, nw, stalls;
        logic acc, prev_stb;

        //            we    addr   din    mode    wt dati   dout  len st  to    err
        vecs[0] = '{1'b1, 8'h34, 8'h12, M_ACK,  1, 8'h00, 8'h00, 2,  0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h34, 8'h00, M_ACK,  0, 8'h5A, 8'h5A, 1,  2, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h10, 8'h00, M_ACK,  3, 8'h3C, 8'h3C, 4,  5, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h20, 8'h00, M_NONE, 0, 8'h11, 8'hFF, 16, 17, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h21, 8'h00, M_BOTH, 0, 8'h77, 8'h77, 1,  2, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h22, 8'h00, M_ERR,  1, 8'h77, 8'hFF, 2,  3, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h40, 8'h99, M_ERR,  0, 8'h00, 8'h00, 1,  0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h41, 8'h55, M_NONE, 0, 8'h00, 8'h00, 16, 0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 8'hFF, 8'h00, M_ACK,  0, 8'h00, 8'h00, 1,  0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 8'h00, M_ACK,  0, 8'h00, 8'h00, 1,  2, 1'b0, 1'b0};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_dout", int'(dout), 0);
        check("rst_rdy", int'(rdy), 1);
        check("rst_stb", int'(wb_stbo), 0);
        check("rst_we", int'(wb_weo), 0);
        check("rst_adr", int'(wb_adro), 0);
        check("rst_dat", int'(wb_dato), 0);
        check("rst_to", int'(to_flag), 0);
        check("rst_err", int'(err_flag), 0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Six back-to-back writes against a slow slave: rdy must track FIFO fullness.
        resp_mode = M_ACK; resp_wait = 3;
        base = n_starts; done0 = n_done;
        q_cnt = 0; nw = 0; stalls = 0; prev_stb = wb_stbo;
        cs = 1'b1; we = 1'b1; addr = 8'h80; din = 8'hA0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (nw == 6 && n_done >= done0 + 6) break;
            acc = cs && rdy;
            tick();
            if (acc) begin
                q_cnt++;
                nw++;
                if (nw < 6) begin
                    addr = 8'h80 + 8'(nw);
                    din  = 8'hA0 + 8'(nw);
                end else begin
                    cs = 1'b0;
                end
            end
            if (wb_stbo && !prev_stb) q_cnt--;
            prev_stb = wb_stbo;
            check("fifo_rdy", int'(rdy), int'(q_cnt != 4));
            if (!rdy) stalls++;
        end
        check("fifo_stalls", stalls, 6);
        check("fifo_nstb", n_starts - base, 6);
        for (int i = 0; i < 6; i++) begin
            if (log_q.size() > base + i) begin
                check("fifo_order_adr", int'(log_q[base+i].adr), 8'h80 + i);
                check("fifo_order_dat", int'(log_q[base+i].dat), 8'hA0 + i);
            end
        end

        // Write then read of the same address: write strobe first, read data from ack.
        resp_mode = M_ACK; resp_wait = 0; resp_data = 8'hA5;
        base = n_starts; done0 = n_done;
        issue(1'b1, 8'h50, 8'hC3);
        issue(1'b0, 8'h50, 8'h00);
        wait_done(done0 + 2, stall);
        check("wr_rd_nstb", n_starts - base, 2);
        if (log_q.size() > base + 1) begin
            check("wr_rd_first_we", int'(log_q[base].we), 1);
            check("wr_rd_first_dat", int'(log_q[base].dat), 8'hC3);
            check("wr_rd_second_we", int'(log_q[base+1].we), 0);
            check("wr_rd_second_adr", int'(log_q[base+1].adr), 8'h50);
        end
        check("wr_rd_stall", stall, 3);
        check("wr_rd_dout", int'(dout), 8'hA5);

        // Timeout while stat_clr is held: set must win on the terminating edge.
        resp_mode = M_NONE;
        stat_clr = 1'b1;
        done0 = n_done;
        issue(1'b0, 8'h60, 8'h00);
        wait_done(done0 + 1, stall);
        check("setwin_to", int'(to_flag), 1);
        check("setwin_len", last_len, 16);
        stat_clr = 1'b0;
        tick();
        check("setwin_hold", int'(to_flag), 1);

        // Reset mid-strobe with two writes still queued.
        resp_mode = M_NONE;
        issue(1'b1, 8'h90, 8'h01);
        issue(1'b1, 8'h91, 8'h02);
        issue(1'b1, 8'h92, 8'h03);
        check("pre_rst_stb", int'(wb_stbo), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_stb", int'(wb_stbo), 0);
        check("mid_rst_rdy", int'(rdy), 1);
        check("mid_rst_dout", int'(dout), 0);
        check("mid_rst_adr", int'(wb_adro), 0);
        check("mid_rst_dat", int'(wb_dato), 0);
        check("mid_rst_we", int'(wb_weo), 0);
        check("mid_rst_to", int'(to_flag), 0);
        base = n_starts;
        repeat (40) tick();
        check("post_rst_nstb", n_starts - base, 0);

        check("strobe_stable", unstable, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Parametrised CPU-to-Wishbone master bridge with posted writes, error termination and a programmable transaction timeout. It sits between the CPU address decoder and the on-chip Wishbone peripherals. Writes are queued in a small FIFO so the CPU keeps running; reads stall the CPU until all queued writes drain and the read terminates. Timeout and bus-error events are reported through sticky status flags.

## Interface
- AW, 8, address width
- DW, 8, data width
- TOW, 4, timeout counter width; a strobe lasts at most 2^TOW cycles
- PWD, 4, posted-write FIFO depth, power of two, minimum 2
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cs  in  1  chip select, CPU request
- we  in  1  1 = write, 0 = read
- addr  in  AW  register address
- din  in  DW  CPU write data
- dout  out  DW  read data, registered
- rdy  out  1  low-true CPU stall, registered
- stat_clr  in  1  pulse that clears both sticky flags
- to_flag  out  1  sticky, set on any timeout
- err_flag  out  1  sticky, set on any wb_erri termination
- wb_stbo  out  1  Wishbone STB/CYC
- wb_weo  out  1  Wishbone WE, 1 = write
- wb_adro  out  AW  Wishbone address
- wb_dato  out  DW  Wishbone write data
- wb_acki  in  1  Wishbone ACK
- wb_erri  in  1  Wishbone ERR
- wb_dati  in  DW  Wishbone read data

## Operation
- Reset values: dout=0, rdy=1, wb_stbo=0, wb_weo=0, wb_adro=0, wb_dato=0, to_flag=0, err_flag=0. The FIFO is flushed, the read-pending bit is cleared and the FSM goes to IDLE.
- Reset mid-transaction: strobe drops on the next edge and queued writes are discarded.
- Acceptance: a request is accepted on any edge where cs=1 and rdy=1.
  - Write: {addr, din} is pushed to the FIFO.
  - Read: addr is latched and read_pending is set.
- rdy next-state is !(fifo_count_next==PWD) && !read_pending_next.
  - Filling the last FIFO slot therefore drops rdy on that same edge.
  - A stalled CPU holds cs/we/addr/din until rdy returns.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and go to WR. Else if read_pending, go to RD. Writes have priority, so a read always observes earlier writes.
  - WR/RD: wb_stbo=1 and the timeout counter is loaded with 2^TOW-1. Each cycle the strobe stays high without termination, the counter decrements.
  - Termination: wb_acki, wb_erri, or counter==0. The strobe drops and the FSM returns to IDLE.
- Termination priority: ack > err > timeout within the same cycle.
- Read result:
  - ack: dout <= wb_dati.
  - err or timeout: dout <= all ones.
  - In every case read_pending clears and rdy rises on the same edge.
- Write termination by err or timeout discards the write and sets the matching flag; the FIFO continues with the next entry.
- Flags: if stat_clr and a set event occur in the same cycle, set wins.

## Timing
- Write accepted at edge N, FIFO empty and FSM idle: wb_stbo high after edge N+1. No CPU stall occurs.
- Read accepted at edge N, FIFO empty: rdy low after N, wb_stbo high after N+1. With ack at edge N+2, dout is valid and rdy=1 after N+2, for a 2-cycle stall.
- Every termination gives at least one cycle with wb_stbo=0 between transactions.
- Timeout with no response: wb_stbo stays high for exactly 2^TOW cycles.
- wb_adro, wb_weo and wb_dato are stable for the whole strobe.

## Structure
- Package wb_bridge_pkg holds:
  - FSM state encoding (IDLE, WR, RD)
  - the all-ones read-fault value as a function of DW
  - the timeout reload constant
- Sub-module wb_wr_fifo: synchronous FIFO of width AW+DW and depth PWD, with push, pop, count, full and empty. Wrap-around uses log2(PWD)+1 bit pointers.

## Test plan
- Single write 0x12 to addr 0x34 with ack after 1 wait cycle -> one strobe with adr=0x34, dat=0x12, we=1; rdy never low.
- PWD+1 back-to-back writes with slow ack -> rdy low exactly while the FIFO is full; all writes appear in order on the bus.
- Write then read of the same address, ack returns 0xA5 -> the write strobe precedes the read strobe; dout=0xA5; rdy rises on the ack edge.
- Read with no ack -> strobe high for 16 cycles (TOW=4), dout=0xFF, to_flag=1; stat_clr then clears it.
- Read terminated by wb_erri with wb_acki also high -> ack wins and dout=wb_dati. Separately, wb_erri alone -> dout=0xFF, err_flag=1.
- rst asserted mid-strobe with 2 writes queued -> strobe drops the next cycle, no further strobes, all outputs at reset values.
